// File: rtl/servo_capture.sv
// Two-channel servo pulse-width decoder, widths in prescaled ticks. SERVO_CAPTURE_FILTER_EN adds a 3-sample majority glitch filter (+2 clk latency).
// Latency: out_data 3 clk and out_valid 4 clk after the falling edge. There is no backpressure: an unread width is overwritten by the next pulse.
module servo_capture #(
    parameter int unsigned TICK_DIV      = 100,
    parameter int unsigned TIMEOUT_TICKS = 25000,
    parameter int unsigned WIDTH_MAX     = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  servo_in,
    output logic [23:0] out_data,
    output logic        out_valid,
    input  logic        out_rd,
    output logic [1:0]  lost
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
`ifdef SERVO_CAPTURE_FILTER_EN
    localparam int PRIME = 5;
`else
    localparam int PRIME = 2;
`endif

    typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH} state_t;

    logic [1:0]       sync1_q, sync2_q, prev_q, level, rise, fall;
    logic [PRIME-1:0] primed_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick, rd_take, valid_q;
    state_t           state_q [2];
    state_t           state_d [2];
    logic [11:0]      wcnt_q [2];
    logic [11:0]      wcnt_d [2];
    logic [11:0]      width_q [2];
    logic [11:0]      width_d [2];
    logic [TW-1:0]    to_q [2];
    logic [TW-1:0]    to_d [2];
    logic [TW:0]      to_inc [2];
    logic [1:0]       new_q, new_d, lost_q, lost_d;

`ifdef SERVO_CAPTURE_FILTER_EN
    logic [1:0] hist1_q, hist2_q, filt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist1_q <= '0;
            hist2_q <= '0;
            filt_q  <= '0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
        end
    end
    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign rise    = level & ~prev_q;
    assign fall    = ~level & prev_q;
    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign rd_take = out_rd & valid_q;

    // ARM only trusts the level once real samples have replaced the reset zeros in the input pipeline.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            wcnt_d[ch]  = wcnt_q[ch];
            width_d[ch] = width_q[ch];
            to_inc[ch]  = {1'b0, to_q[ch]} + (TW+1)'(tick);
            to_d[ch]    = to_inc[ch][TW-1:0];
            lost_d[ch]  = lost_q[ch];
            new_d[ch]   = new_q[ch] & ~rd_take;
            case (state_q[ch])
                ARM: begin
                    to_d[ch] = '0;
                    if (primed_q[PRIME-1] && !level[ch]) state_d[ch] = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise[ch]) begin
                        wcnt_d[ch]  = '0;
                        to_d[ch]    = '0;
                        state_d[ch] = HIGH;
                    end else if (to_inc[ch] >= (TW+1)'(TIMEOUT_TICKS)) begin
                        lost_d[ch]  = 1'b1;
                        width_d[ch] = '0;
                        state_d[ch] = ARM;
                    end
                end
                HIGH: begin
                    if (tick && wcnt_q[ch] < 12'(WIDTH_MAX)) wcnt_d[ch] = wcnt_q[ch] + 12'd1;
                    if (fall[ch]) begin
                        width_d[ch] = wcnt_q[ch];
                        new_d[ch]   = 1'b1;
                        lost_d[ch]  = 1'b0;
                        state_d[ch] = WAIT_RISE;
                    end else if (to_inc[ch] >= (TW+1)'(TIMEOUT_TICKS)) begin
                        lost_d[ch]  = 1'b1;
                        width_d[ch] = '0;
                        state_d[ch] = ARM;
                    end
                end
                default: state_d[ch] = ARM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            primed_q <= '0;
            presc_q  <= '0;
            new_q    <= '0;
            lost_q   <= '0;
            valid_q  <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= ARM;
                wcnt_q[ch]  <= '0;
                width_q[ch] <= '0;
                to_q[ch]    <= '0;
            end
        end else begin
            sync1_q  <= servo_in;
            sync2_q  <= sync1_q;
            prev_q   <= level;
            primed_q <= {primed_q[PRIME-2:0], 1'b1};
            presc_q  <= presc_d;
            new_q    <= new_d;
            lost_q   <= lost_d;
            valid_q  <= |new_q;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                wcnt_q[ch]  <= wcnt_d[ch];
                width_q[ch] <= width_d[ch];
                to_q[ch]    <= to_d[ch];
            end
        end
    end

    assign out_data  = {width_q[1], width_q[0]};
    assign out_valid = valid_q;
    assign lost      = lost_q;
endmodule

// File: tb/tb_servo_capture.sv
// Bench for servo_capture: directed scenarios plus random pulse trains and reads, checked every cycle
// against a timestamp-based reference model; tick counts come from cycle arithmetic.
module tb_servo_capture;
    localparam int D    = 4;
    localparam int TO   = 100;
    localparam int WMAX = 20;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        s0     = 1'b0;
    logic        s1     = 1'b0;
    logic        out_rd = 1'b0;
    logic [1:0]  servo_in;
    logic [23:0] out_data;
    logic        out_valid;
    logic [1:0]  lost;

    assign servo_in = {s1, s0};
    always #5 clk = ~clk;

    servo_capture #(.TICK_DIV(D), .TIMEOUT_TICKS(TO), .WIDTH_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .servo_in(servo_in), .out_data(out_data),
        .out_valid(out_valid), .out_rd(out_rd), .lost(lost)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Reference model: cycle c counts from reset release; x(k) is servo_in as sampled at edge k.
    int c;
    int mode [2];   // 0 = waiting for a low line, 1 = idle low, 2 = inside a pulse
    int ref_c [2];  // cycle the timeout window started (last rise or re-arm)
    int m_w [2];
    bit m_new [2];
    bit m_lost [2];
    bit m_valid;
    bit x0 [2];
    bit xm1 [2];
    bit xm2 [2];

    function automatic int ticks(input int a, input int b);
        if (b < a) return 0;
        return (b + 1) / D - a / D;
    endfunction

    task automatic model_reset();
        c = 0;
        m_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; ref_c[k] = 0; m_w[k] = 0; m_new[k] = 1'b0; m_lost[k] = 1'b0;
            x0[k] = 1'b0; xm1[k] = 1'b0; xm2[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit rdt, nv, lvl, prv, latch;
        int t;
        rdt = out_rd && m_valid;
        nv  = m_new[0] || m_new[1];
        for (int k = 0; k < 2; k++) begin
            lvl   = xm1[k];
            prv   = xm2[k];
            latch = 1'b0;
            if (mode[k] == 0) begin
                if (c >= 2 && !lvl) begin mode[k] = 1; ref_c[k] = c; end
            end else if (mode[k] == 1) begin
                if (lvl && !prv) begin
                    mode[k] = 2; ref_c[k] = c;
                end else if (ticks(ref_c[k] + 1, c) >= TO) begin
                    mode[k] = 0; m_lost[k] = 1'b1; m_w[k] = 0;
                end
            end else begin
                if (!lvl && prv) begin
                    t = ticks(ref_c[k] + 1, c - 1);
                    m_w[k] = (t > WMAX) ? WMAX : t;
                    m_lost[k] = 1'b0; latch = 1'b1; mode[k] = 1;
                end else if (ticks(ref_c[k] + 1, c) >= TO) begin
                    mode[k] = 0; m_lost[k] = 1'b1; m_w[k] = 0;
                end
            end
            if (latch) m_new[k] = 1'b1;
            else if (rdt) m_new[k] = 1'b0;
            xm2[k] = xm1[k];
            xm1[k] = x0[k];
            x0[k]  = servo_in[k];
        end
        m_valid = nv;
        c++;
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        else begin
            chk("cyc_out_valid", out_valid, m_valid);
            chk("cyc_width_ch0", out_data[11:0], m_w[0]);
            chk("cyc_width_ch1", out_data[23:12], m_w[1]);
            chk("cyc_lost_ch0", lost[0], m_lost[0]);
            chk("cyc_lost_ch1", lost[1], m_lost[1]);
            model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read1();
        out_rd = 1'b1;
        cyc(1);
        out_rd = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic v);
        if (k == 0) s0 = v;
        else s1 = v;
    endtask

    task automatic rand_ch(input int k);
        int r, lo, hi;
        repeat (40) begin
            r  = $urandom_range(0, 19);
            lo = (r == 0) ? $urandom_range(420, 480) : $urandom_range(6, 70);
            hi = (r < 3) ? 1 : (r == 3) ? $urandom_range(100, 140) : $urandom_range(2, 90);
            set_ch(k, 1'b0);
            cyc(lo);
            set_ch(k, 1'b1);
            cyc(hi);
        end
        set_ch(k, 1'b0);
    endtask

    task automatic rand_rd();
        repeat (4500) begin
            out_rd = ($urandom_range(0, 5) == 0);
            cyc(1);
        end
        out_rd = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_lost", lost, 0);
        cyc(5);

        // single 40-clk pulse on ch0 and its output latency
        s0 = 1'b1; cyc(40); s0 = 1'b0;
        cyc(2);
        chk("t1_valid_at_2", out_valid, 0);
        chk("t1_data_at_2", out_data[11:0], 0);
        cyc(1);
        chk_rng("t1_width_at_3", out_data[11:0], 9, 11);
        chk("t1_valid_at_3", out_valid, 0);
        cyc(1);
        chk("t1_valid_at_4", out_valid, 1);
        chk("t1_width_ch1", out_data[23:12], 0);
        chk("t1_lost", lost, 0);
        read1(); cyc(1);
        chk("t1_valid_after_rd", out_valid, 0);

        // both channels, then read and an ignored read
        cyc(10);
        s0 = 1'b1; s1 = 1'b1; cyc(20); s0 = 1'b0; cyc(40); s1 = 1'b0; cyc(5);
        chk_rng("t2_width_ch0", out_data[11:0], 4, 6);
        chk_rng("t2_width_ch1", out_data[23:12], 14, 16);
        chk("t2_valid", out_valid, 1);
        read1(); cyc(1);
        chk("t2_valid_after_rd", out_valid, 0);
        read1(); cyc(3);
        chk_rng("t2_idle_rd_ch0", out_data[11:0], 4, 6);
        chk_rng("t2_idle_rd_ch1", out_data[23:12], 14, 16);
        chk("t2_idle_rd_valid", out_valid, 0);

        // read strobe in the very cycle ch1 latches
        s0 = 1'b1; cyc(20); s0 = 1'b0; cyc(6);
        chk("t3_valid_pre", out_valid, 1);
        s1 = 1'b1; cyc(30); s1 = 1'b0; cyc(2);
        out_rd = 1'b1; cyc(1); out_rd = 1'b0;
        chk_rng("t3_width_ch1", out_data[23:12], 6, 8);
        cyc(1);
        chk("t3_valid_kept", out_valid, 1);
        read1(); cyc(1);
        chk("t3_valid_cleared", out_valid, 0);

        // saturation, then timeout on a stuck-high line and recovery
        cyc(5);
        s0 = 1'b1; cyc(120); s0 = 1'b0; cyc(5);
        chk("t4_width_sat", out_data[11:0], WMAX);
        read1(); cyc(5);
        s0 = 1'b1; cyc(600);
        chk("t4_lost_set", lost[0], 1);
        chk("t4_width_zeroed", out_data[11:0], 0);
        s0 = 1'b0; cyc(10);
        s0 = 1'b1; cyc(40); s0 = 1'b0; cyc(5);
        chk("t4_lost_cleared", lost[0], 0);
        chk_rng("t4_width_recovered", out_data[11:0], 9, 11);
        chk("t4_valid", out_valid, 1);

        // asynchronous reset mid-pulse, then line high at reset release
        s0 = 1'b1; cyc(10);
        chk("t5_valid_pre", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_data", out_data, 0);
        chk("t5_async_lost", lost, 0);
        cyc(2);
        rst = 1'b0;
        cyc(30); s0 = 1'b0; cyc(10);
        chk("t5_no_partial", out_valid, 0);
        s0 = 1'b1; cyc(40); s0 = 1'b0; cyc(5);
        chk("t5_valid_next", out_valid, 1);
        chk_rng("t5_width_next", out_data[11:0], 9, 11);

        // single-clock glitch on ch1
        read1(); cyc(3);
        s1 = 1'b1; cyc(1); s1 = 1'b0; cyc(4);
`ifdef SERVO_CAPTURE_FILTER_EN
        chk("t6_glitch_valid", out_valid, 0);
`else
        chk("t6_glitch_valid", out_valid, 1);
        chk("t6_glitch_width", out_data[23:12], 0);
`endif

        fork
            rand_ch(0);
            rand_ch(1);
            rand_rd();
        join
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
